// File: rtl/jk_universal_register.sv
// ---------------------------------------------------------------------------
// jk_universal_register
//
// Purpose:
//   WIDTH-bit register bank with per-bit JK flip-flop behaviour. A 3-bit mode
//   selects between hold, per-bit JK update, parallel load, shift left/right,
//   up/down count and whole-word toggle. It is the parametrised, multi-bit
//   form of a single JK flip-flop, and the Q/Qbar pair behaves the same way.
//
// Parameters:
//   WIDTH      register width in bits (>= 2)
//   RESET_VAL  value loaded into Q on reset (zero-extended or truncated to WIDTH)
//
// Ports:
//   i_clk       clock; all state updates happen on the rising edge
//   i_n_reset   synchronous reset, active-low, sampled on the rising edge
//   i_en        clock enable; 0 holds Q (Wrap and ShiftOut still clear)
//   i_mode      operation select: HOLD, JK, LOAD, SHL, SHR, UP, DOWN, TOGGLE
//   i_j         per-bit J inputs; also the parallel-load data in LOAD mode
//   i_k         per-bit K inputs
//   i_ser_in    serial input for the shift modes
//   o_q         register state
//   o_qbar      bitwise complement of o_q (derived from o_q, never stored)
//   o_wrap      registered one-cycle pulse: the counter wrapped on the last edge
//   o_shift_out registered bit shifted out on the last shift edge
//   o_tc        combinational terminal count: the next count edge will wrap
// ---------------------------------------------------------------------------
module jk_universal_register #(
    parameter int          WIDTH     = 8,
    parameter logic [63:0] RESET_VAL = 64'd0
) (
    input  logic             i_clk,
    input  logic             i_n_reset,
    input  logic             i_en,
    input  logic [2:0]       i_mode,
    input  logic [WIDTH-1:0] i_j,
    input  logic [WIDTH-1:0] i_k,
    input  logic             i_ser_in,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_qbar,
    output logic             o_wrap,
    output logic             o_shift_out,
    output logic             o_tc
);

    localparam logic [2:0] MODE_HOLD   = 3'b000;
    localparam logic [2:0] MODE_JK     = 3'b001;
    localparam logic [2:0] MODE_LOAD   = 3'b010;
    localparam logic [2:0] MODE_SHL    = 3'b011;
    localparam logic [2:0] MODE_SHR    = 3'b100;
    localparam logic [2:0] MODE_UP     = 3'b101;
    localparam logic [2:0] MODE_DOWN   = 3'b110;
    localparam logic [2:0] MODE_TOGGLE = 3'b111;

    localparam logic [WIDTH-1:0] RST_Q    = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_shift_out;

    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_next;
    logic             w_shift_next;
    logic             w_at_ones;
    logic             w_at_zero;

    assign w_at_ones = (r_q == ALL_ONES);
    assign w_at_zero = (r_q == ALL_ZERO);

    // Next-state selection; Wrap and ShiftOut default to 0 so they are pulses
    always_comb begin
        w_q_next     = r_q;
        w_wrap_next  = 1'b0;
        w_shift_next = 1'b0;
        if (i_en) begin
            case (i_mode)
                MODE_HOLD: begin
                    w_q_next = r_q;
                end
                MODE_JK: begin
                    // Characteristic equation Q+ = J&~Q | ~K&Q, applied per bit
                    w_q_next = (i_j & ~r_q) | (~i_k & r_q);
                end
                MODE_LOAD: begin
                    w_q_next = i_j;
                end
                MODE_SHL: begin
                    w_q_next     = {r_q[WIDTH-2:0], i_ser_in};
                    w_shift_next = r_q[WIDTH-1];
                end
                MODE_SHR: begin
                    w_q_next     = {i_ser_in, r_q[WIDTH-1:1]};
                    w_shift_next = r_q[0];
                end
                MODE_UP: begin
                    w_q_next    = r_q + ONE;
                    w_wrap_next = w_at_ones;
                end
                MODE_DOWN: begin
                    w_q_next    = r_q - ONE;
                    w_wrap_next = w_at_zero;
                end
                MODE_TOGGLE: begin
                    w_q_next = ~r_q;
                end
                default: begin
                    w_q_next = r_q;
                end
            endcase
        end else begin
            w_q_next = r_q;
        end
    end

    // State register with synchronous active-low reset overriding En and Mode
    always_ff @(posedge i_clk) begin
        if (!i_n_reset) begin
            r_q         <= RST_Q;
            r_wrap      <= 1'b0;
            r_shift_out <= 1'b0;
        end else begin
            r_q         <= w_q_next;
            r_wrap      <= w_wrap_next;
            r_shift_out <= w_shift_next;
        end
    end

    // Terminal count looks only at Mode and Q, deliberately ignoring En
    always_comb begin
        o_tc = 1'b0;
        if (i_mode == MODE_UP) begin
            o_tc = w_at_ones;
        end else if (i_mode == MODE_DOWN) begin
            o_tc = w_at_zero;
        end else begin
            o_tc = 1'b0;
        end
    end

    assign o_q         = r_q;
    assign o_qbar      = ~r_q;
    assign o_wrap      = r_wrap;
    assign o_shift_out = r_shift_out;

endmodule

// File: tb/tb_jk_universal_register.sv
module tb_jk_universal_register;

    localparam int          WIDTH = 8;
    localparam logic [63:0] RVAL  = 64'h5A;

    localparam logic [2:0] HOLD = 3'b000, JK = 3'b001, LOAD = 3'b010, SHL = 3'b011;
    localparam logic [2:0] SHR = 3'b100, UP = 3'b101, DOWN = 3'b110, TOG = 3'b111;

    logic             clk = 1'b0;
    logic             n_reset;
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             ser_in;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             wrap;
    logic             shift_out;
    logic             tc;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             wrap;
        logic             sout;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    jk_universal_register #(.WIDTH(WIDTH), .RESET_VAL(RVAL)) dut (
        .i_clk       (clk),
        .i_n_reset   (n_reset),
        .i_en        (en),
        .i_mode      (mode),
        .i_j         (j),
        .i_k         (k),
        .i_ser_in    (ser_in),
        .o_q         (q),
        .o_qbar      (qbar),
        .o_wrap      (wrap),
        .o_shift_out (shift_out),
        .o_tc        (tc)
    );

    always #5 clk = ~clk;

    // Monitor: after every rising edge, pop the expected result and compare
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (q !== e.q) begin
                failures++;
                $display("FAIL q: got %h expected %h", q, e.q);
            end
            checks++;
            if (qbar !== ~e.q) begin
                failures++;
                $display("FAIL qbar: got %h expected %h", qbar, ~e.q);
            end
            checks++;
            if (wrap !== e.wrap) begin
                failures++;
                $display("FAIL wrap: got %b expected %b (q exp %h)", wrap, e.wrap, e.q);
            end
            checks++;
            if (shift_out !== e.sout) begin
                failures++;
                $display("FAIL shift_out: got %b expected %b (q exp %h)", shift_out, e.sout, e.q);
            end
        end
    end

    // Drive one edge's inputs at the falling edge; exp_tc < 0 skips the Tc check
    task automatic step(input logic nr, input logic e_n, input logic [2:0] m,
                        input logic [WIDTH-1:0] jv, input logic [WIDTH-1:0] kv,
                        input logic s, input logic [WIDTH-1:0] eq,
                        input logic ew, input logic es, input int exp_tc);
        exp_t ex;
        @(negedge clk);
        n_reset = nr; en = e_n; mode = m; j = jv; k = kv; ser_in = s;
        #1;
        if (exp_tc >= 0) begin
            checks++;
            if (tc !== exp_tc[0]) begin
                failures++;
                $display("FAIL tc: got %b expected %0d (mode %b)", tc, exp_tc, m);
            end
        end
        ex.q = eq; ex.wrap = ew; ex.sout = es;
        sb.push_back(ex);
    endtask

    // Pulse reset low between edges only; the following edge must not reset
    task automatic glitch_hold(input logic [WIDTH-1:0] eq);
        exp_t ex;
        @(negedge clk);
        en = 1'b1; mode = HOLD; n_reset = 1'b0;
        #2;
        n_reset = 1'b1;
        ex.q = eq; ex.wrap = 1'b0; ex.sout = 1'b0;
        sb.push_back(ex);
    endtask

    initial begin
        n_reset = 1'b0; en = 1'b1; mode = UP; j = 8'h00; k = 8'h00; ser_in = 1'b0;
        //    nr    en    mode  J      K      ser   Q      wrap  sout  tc
        step(1'b0, 1'b1, UP,   8'h00, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0, -1);
        step(1'b0, 1'b1, UP,   8'h00, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, LOAD, 8'h0F, 8'h00, 1'b0, 8'h0F, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, JK,   8'hAA, 8'h66, 1'b0, 8'hA9, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, LOAD, 8'hFE, 8'h00, 1'b0, 8'hFE, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, UP,   8'h00, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, UP,   8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1);
        step(1'b1, 1'b1, HOLD, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, DOWN, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1);
        step(1'b1, 1'b1, DOWN, 8'h00, 8'h00, 1'b0, 8'hFE, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, LOAD, 8'h81, 8'h00, 1'b0, 8'h81, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, SHL,  8'h00, 8'h00, 1'b0, 8'h02, 1'b0, 1'b1, 0);
        step(1'b1, 1'b1, SHR,  8'h00, 8'h00, 1'b1, 8'h81, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, SHL,  8'h00, 8'h00, 1'b1, 8'h03, 1'b0, 1'b1, 0);
        step(1'b1, 1'b0, SHL,  8'h00, 8'h00, 1'b0, 8'h03, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, TOG,  8'h00, 8'h00, 1'b0, 8'h03, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, TOG,  8'h00, 8'h00, 1'b0, 8'h03, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, TOG,  8'h00, 8'h00, 1'b0, 8'h03, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, TOG,  8'h00, 8'h00, 1'b0, 8'hFC, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, LOAD, 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, UP,   8'h00, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1);
        step(1'b0, 1'b1, UP,   8'h00, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0, 1);
        step(1'b1, 1'b1, LOAD, 8'h3C, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 0);
        glitch_hold(8'h3C);
        step(1'b0, 1'b1, HOLD, 8'h00, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, DOWN, 8'h00, 8'h00, 1'b0, 8'h59, 1'b0, 1'b0, 0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
